rggen_bit_field_rwlk: RTL and testbench

Parametrised successor to the team's lock/enable-controlled bit field. One register field of WIDTH bits whose write permission comes from a static lock input, a static enable input, or a two-key unlock sequence with a bounded unlock window. Sits inside a generated register block, driven by the register's command/select/write strobes, with its value fanned out to user logic.

---
 rtl/rggen_bit_field_lock_pkg.sv | 22 ++
 rtl/rggen_bit_field_unlock_fsm.sv | 93 +++++++++
 rtl/rggen_bit_field_rwlk.sv | 101 ++++++++++
 tb/tb_rggen_bit_field_rwlk.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rggen_bit_field_lock_pkg.sv
// ============================================================================
// Module   : rggen_bit_field_lock_pkg
// Brief    : Shared types and lock-mode constants for the lockable bit field.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rggen_bit_field_lock_pkg;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        ARMED    = 2'd1,
        UNLOCKED = 2'd2
    } unlock_state_e;

    localparam int LOCK_MODE_ENABLE = 0;
    localparam int LOCK_MODE_LOCK   = 1;
    localparam int LOCK_MODE_KEY    = 2;

endpackage

`default_nettype wire

// File: rtl/rggen_bit_field_unlock_fsm.sv
// ============================================================================
// Module   : rggen_bit_field_unlock_fsm
// Brief    : Two-key unlock sequencer with a bounded unlock window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rggen_bit_field_unlock_fsm
    import rggen_bit_field_lock_pkg::*;
#(
    parameter int unsigned           KEY_WIDTH     = 8,
    parameter logic [KEY_WIDTH-1:0]  KEY0          = 8'h5A,
    parameter logic [KEY_WIDTH-1:0]  KEY1          = 8'hA5,
    parameter int unsigned           UNLOCK_WINDOW = 16,
    parameter bit                    ONE_SHOT      = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_force_lock,
    input  logic                 i_key_valid,
    input  logic [KEY_WIDTH-1:0] i_key_data,
    input  logic                 i_write_accepted,
    output logic                 o_unlocked
);

    localparam int unsigned c_cnt_width = $clog2(UNLOCK_WINDOW + 1);
    localparam logic [c_cnt_width-1:0] c_cnt_start = c_cnt_width'(UNLOCK_WINDOW - 1);

    unlock_state_e          r_state;
    unlock_state_e          w_state_next;
    logic [c_cnt_width-1:0] r_count;
    logic [c_cnt_width-1:0] w_count_next;
    logic                   w_key0_hit;
    logic                   w_key1_hit;

    assign w_key0_hit = i_key_valid && (i_key_data == KEY0);
    assign w_key1_hit = i_key_valid && (i_key_data == KEY1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOCKED;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    // Counter is only meaningful in UNLOCKED; it is parked at zero elsewhere.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        if (i_force_lock) begin
            w_state_next = LOCKED;
            w_count_next = '0;
        end else begin
            case (r_state)
                LOCKED: begin
                    if (w_key0_hit) begin
                        w_state_next = ARMED;
                    end
                end
                ARMED: begin
                    if (w_key1_hit) begin
                        w_state_next = UNLOCKED;
                        w_count_next = c_cnt_start;
                    end else if (w_key0_hit) begin
                        w_state_next = ARMED;
                    end else if (i_key_valid) begin
                        w_state_next = LOCKED;
                    end
                end
                UNLOCKED: begin
                    if ((r_count == '0) || (ONE_SHOT && i_write_accepted)) begin
                        w_state_next = LOCKED;
                        w_count_next = '0;
                    end else begin
                        w_count_next = r_count - 1'b1;
                    end
                end
                default: begin
                    w_state_next = LOCKED;
                    w_count_next = '0;
                end
            endcase
        end
    end

    assign o_unlocked = (r_state == UNLOCKED);

endmodule

`default_nettype wire

// File: rtl/rggen_bit_field_rwlk.sv
// ============================================================================
// Module   : rggen_bit_field_rwlk
// Brief    : Register bit field writable under static lock/enable or key unlock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rggen_bit_field_rwlk
    import rggen_bit_field_lock_pkg::*;
#(
    parameter int                    LOCK_MODE     = 1,
    parameter int unsigned           WIDTH         = 1,
    parameter logic [WIDTH-1:0]      INITIAL_VALUE = '0,
    parameter int unsigned           KEY_WIDTH     = 8,
    parameter logic [KEY_WIDTH-1:0]  KEY0          = 8'h5A,
    parameter logic [KEY_WIDTH-1:0]  KEY1          = 8'hA5,
    parameter int unsigned           UNLOCK_WINDOW = 16,
    parameter bit                    ONE_SHOT      = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_lock_or_enable,
    input  logic                 i_command_valid,
    input  logic                 i_select,
    input  logic                 i_write,
    input  logic [WIDTH-1:0]     i_write_data,
    input  logic [WIDTH-1:0]     i_write_mask,
    input  logic                 i_key_valid,
    input  logic [KEY_WIDTH-1:0] i_key_data,
    output logic [WIDTH-1:0]     o_value,
    output logic                 o_writable,
    output logic                 o_write_accepted,
    output logic                 o_write_rejected
);

    logic [WIDTH-1:0] r_value;
    logic             r_write_accepted;
    logic             r_write_rejected;
    logic             w_writable;
    logic             w_write_attempt;
    logic             w_write_accepted;

    assign w_write_attempt  = i_command_valid & i_select & i_write;
    assign w_write_accepted = w_write_attempt & w_writable;

    generate
        if (LOCK_MODE == LOCK_MODE_KEY) begin : g_key_unlock
            logic w_unlocked;

            rggen_bit_field_unlock_fsm #(
                .KEY_WIDTH     (KEY_WIDTH),
                .KEY0          (KEY0),
                .KEY1          (KEY1),
                .UNLOCK_WINDOW (UNLOCK_WINDOW),
                .ONE_SHOT      (ONE_SHOT)
            ) u_unlock_fsm (
                .clk              (clk),
                .rst              (rst),
                .i_force_lock     (i_lock_or_enable),
                .i_key_valid      (i_key_valid),
                .i_key_data       (i_key_data),
                .i_write_accepted (w_write_accepted),
                .o_unlocked       (w_unlocked)
            );

            assign w_writable = w_unlocked & ~i_lock_or_enable;
        end else begin : g_static_lock
            // Key inputs have no function in the static lock modes.
            logic w_unused_keys;
            assign w_unused_keys = ^{i_key_valid, i_key_data};

            if (LOCK_MODE == LOCK_MODE_ENABLE) begin : g_enable
                assign w_writable = i_lock_or_enable;
            end else begin : g_lock
                assign w_writable = ~i_lock_or_enable;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_value          <= INITIAL_VALUE;
            r_write_accepted <= 1'b0;
            r_write_rejected <= 1'b0;
        end else begin
            if (w_write_accepted) begin
                r_value <= (i_write_data & i_write_mask) | (r_value & ~i_write_mask);
            end
            r_write_accepted <= w_write_accepted;
            r_write_rejected <= w_write_attempt & ~w_writable;
        end
    end

    assign o_value          = r_value;
    assign o_writable       = w_writable;
    assign o_write_accepted = r_write_accepted;
    assign o_write_rejected = r_write_rejected;

endmodule

`default_nettype wire

// File: tb/tb_rggen_bit_field_rwlk.sv
// ============================================================================
// Module   : tb_rggen_bit_field_rwlk
// Brief    : Directed self-checking bench for the lockable bit field.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rggen_bit_field_rwlk;

    logic       clk = 1'b0;
    logic       rst;
    logic       lock;
    logic       cmd_valid;
    logic       sel;
    logic       wr_en;
    logic [7:0] wdata;
    logic [7:0] wmask;
    logic       key_valid;
    logic [7:0] key_data;

    logic [7:0] m0_value, m1_value, m2_value, os_value;
    logic       m0_wbl, m1_wbl, m2_wbl, os_wbl;
    logic       m0_acc, m1_acc, m2_acc, os_acc;
    logic       m0_rej, m1_rej, m2_rej, os_rej;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    rggen_bit_field_rwlk #(.LOCK_MODE(0), .WIDTH(8), .INITIAL_VALUE(8'h81)) u_dut_m0 (
        .clk(clk), .rst(rst), .i_lock_or_enable(lock), .i_command_valid(cmd_valid),
        .i_select(sel), .i_write(wr_en), .i_write_data(wdata), .i_write_mask(wmask),
        .i_key_valid(key_valid), .i_key_data(key_data), .o_value(m0_value),
        .o_writable(m0_wbl), .o_write_accepted(m0_acc), .o_write_rejected(m0_rej));

    rggen_bit_field_rwlk #(.LOCK_MODE(1), .WIDTH(8), .INITIAL_VALUE(8'h3C)) u_dut_m1 (
        .clk(clk), .rst(rst), .i_lock_or_enable(lock), .i_command_valid(cmd_valid),
        .i_select(sel), .i_write(wr_en), .i_write_data(wdata), .i_write_mask(wmask),
        .i_key_valid(key_valid), .i_key_data(key_data), .o_value(m1_value),
        .o_writable(m1_wbl), .o_write_accepted(m1_acc), .o_write_rejected(m1_rej));

    rggen_bit_field_rwlk #(.LOCK_MODE(2), .WIDTH(8), .INITIAL_VALUE(8'h42),
                           .UNLOCK_WINDOW(4), .ONE_SHOT(1'b0)) u_dut_m2 (
        .clk(clk), .rst(rst), .i_lock_or_enable(lock), .i_command_valid(cmd_valid),
        .i_select(sel), .i_write(wr_en), .i_write_data(wdata), .i_write_mask(wmask),
        .i_key_valid(key_valid), .i_key_data(key_data), .o_value(m2_value),
        .o_writable(m2_wbl), .o_write_accepted(m2_acc), .o_write_rejected(m2_rej));

    rggen_bit_field_rwlk #(.LOCK_MODE(2), .WIDTH(8), .INITIAL_VALUE(8'h00),
                           .UNLOCK_WINDOW(4), .ONE_SHOT(1'b1)) u_dut_os (
        .clk(clk), .rst(rst), .i_lock_or_enable(lock), .i_command_valid(cmd_valid),
        .i_select(sel), .i_write(wr_en), .i_write_data(wdata), .i_write_mask(wmask),
        .i_key_valid(key_valid), .i_key_data(key_data), .o_value(os_value),
        .o_writable(os_wbl), .o_write_accepted(os_acc), .o_write_rejected(os_rej));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] d, input logic [7:0] m);
        cmd_valid = 1'b1; sel = 1'b1; wr_en = 1'b1; wdata = d; wmask = m;
        tick();
        cmd_valid = 1'b0; sel = 1'b0; wr_en = 1'b0;
    endtask

    task automatic send_key(input logic [7:0] k);
        key_valid = 1'b1; key_data = k;
        tick();
        key_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; lock = 1'b0; cmd_valid = 1'b0; sel = 1'b0; wr_en = 1'b0;
        wdata = '0; wmask = '0; key_valid = 1'b0; key_data = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_m1_value", m1_value, 8'h3C);
        check("rst_m1_acc",   m1_acc,   1'b0);
        check("rst_m1_rej",   m1_rej,   1'b0);
        check("rst_m1_wbl",   m1_wbl,   1'b1);
        check("rst_m0_wbl",   m0_wbl,   1'b0);
        check("rst_m2_value", m2_value, 8'h42);
        check("rst_m2_wbl",   m2_wbl,   1'b0);

        // Static lock/enable modes
        do_write(8'hFF, 8'h0F);
        check("m1_masked_value", m1_value, 8'h3F);
        check("m1_acc_pulse",    m1_acc,   1'b1);
        check("m1_no_rej",       m1_rej,   1'b0);
        check("m0_rej_pulse",    m0_rej,   1'b1);
        check("m0_value_kept",   m0_value, 8'h81);
        check("m2_locked_rej",   m2_rej,   1'b1);
        lock = 1'b1;
        #1;
        check("m1_locked_wbl", m1_wbl, 1'b0);
        check("m0_enable_wbl", m0_wbl, 1'b1);
        do_write(8'h00, 8'hFF);
        check("m1_locked_value", m1_value, 8'h3F);
        check("m1_rej_pulse",    m1_rej,   1'b1);
        check("m1_no_acc",       m1_acc,   1'b0);
        check("m0_written",      m0_value, 8'h00);
        tick();
        check("m1_rej_one_cycle", m1_rej, 1'b0);
        lock = 1'b0;

        // Unlock window: write with KEY1 rejected, last window cycle accepted
        send_key(8'h5A);
        key_valid = 1'b1; key_data = 8'hA5;
        do_write(8'h77, 8'hFF);
        key_valid = 1'b0;
        check("key1_same_cycle_rej", m2_rej,   1'b1);
        check("key1_same_cycle_val", m2_value, 8'h42);
        check("unlocked_wbl",        m2_wbl,   1'b1);
        tick();
        tick();
        tick();
        check("window_last_wbl", m2_wbl, 1'b1);
        do_write(8'h11, 8'hFF);
        check("window_last_value", m2_value, 8'h11);
        check("window_last_acc",   m2_acc,   1'b1);
        check("window_end_wbl",    m2_wbl,   1'b0);
        do_write(8'h22, 8'hFF);
        check("window_over_rej",   m2_rej,   1'b1);
        check("window_over_value", m2_value, 8'h11);

        // Repeated KEY0 then KEY1 unlocks; force-lock relocks
        send_key(8'h5A);
        send_key(8'h5A);
        send_key(8'hA5);
        check("rearm_unlocked_wbl", m2_wbl, 1'b1);
        lock = 1'b1;
        #1;
        check("force_lock_comb_wbl", m2_wbl, 1'b0);
        tick();
        lock = 1'b0;
        #1;
        check("force_lock_state_wbl", m2_wbl, 1'b0);
        do_write(8'h33, 8'hFF);
        check("force_lock_rej",   m2_rej,   1'b1);
        check("force_lock_value", m2_value, 8'h11);

        // Wrong middle key aborts the sequence
        send_key(8'h5A);
        send_key(8'h33);
        send_key(8'hA5);
        check("bad_key_wbl", m2_wbl, 1'b0);
        do_write(8'h44, 8'hFF);
        check("bad_key_rej",   m2_rej,   1'b1);
        check("bad_key_value", m2_value, 8'h11);

        // One-shot relock versus open window
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_os_value", os_value, 8'h00);
        check("rst2_m2_value", m2_value, 8'h42);
        send_key(8'h5A);
        send_key(8'hA5);
        do_write(8'h01, 8'hFF);
        check("os_first_acc",   os_acc,   1'b1);
        check("os_first_value", os_value, 8'h01);
        check("os_relocked",    os_wbl,   1'b0);
        do_write(8'h02, 8'hFF);
        check("os_second_rej",   os_rej,   1'b1);
        check("os_second_value", os_value, 8'h01);
        check("m2_second_acc",   m2_acc,   1'b1);
        check("m2_second_value", m2_value, 8'h02);

        // Reset mid-window overrides a concurrent write and key
        do_write(8'hAA, 8'hFF);
        check("m2_window_write", m2_value, 8'hAA);
        rst = 1'b1; key_valid = 1'b1; key_data = 8'h5A;
        do_write(8'h55, 8'hFF);
        rst = 1'b0; key_valid = 1'b0;
        #1;
        check("rst_mid_value", m2_value, 8'h42);
        check("rst_mid_wbl",   m2_wbl,   1'b0);
        check("rst_mid_acc",   m2_acc,   1'b0);
        check("rst_mid_rej",   m2_rej,   1'b0);
        check("rst_mid_m1",    m1_value, 8'h3C);
        tick();
        check("rst_mid_wbl_after", m2_wbl, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
